// File: rtl/md_pkg.sv
// Shared constants and types for the molecular-dynamics position-cache datapath.
package md_pkg;
    localparam int NUM_NEIGHBOR_CELLS = 13;
    localparam int PARTICLE_ID_WIDTH  = 7;

    typedef enum logic [2:0] {
        IDLE,
        RD_NUM,
        WAIT_CNT,
        BCAST,
        DRAIN
    } pos_rd_state_t;
endpackage

// File: rtl/cell_count_max.sv
// Combinational maximum over the per-cache particle counts (index 0 = home cell).
module cell_count_max #(
    parameter int NUM_CELLS = 14,
    parameter int W         = 7
) (
    input  logic [NUM_CELLS*W-1:0] counts,
    output logic [W-1:0]           max_cnt
);
    genvar gi;
    generate
        // Each stage keeps its own running maximum so the chain stays acyclic.
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_max
            logic [W-1:0] run_max;
            if (gi == 0) begin : g_first
                assign run_max = counts[W-1:0];
            end else begin : g_next
                assign run_max = (counts[gi*W +: W] > g_max[gi-1].run_max) ?
                                 counts[gi*W +: W] : g_max[gi-1].run_max;
            end
        end
    endgenerate

    assign max_cnt = g_max[NUM_CELLS-1].run_max;
endmodule

// File: rtl/pos_read_ctrl.sv
// Read-sequence initiator for the position-cache port: reads count words, then
// broadcasts every neighbour id twice (phase 0/1) for each home reference particle.
module pos_read_ctrl
    import md_pkg::*;
#(
    parameter int NUM_NEIGHBOR_CELLS_P = NUM_NEIGHBOR_CELLS,
    parameter int PARTICLE_ID_WIDTH_P  = PARTICLE_ID_WIDTH,
    parameter int RD_LATENCY           = 1,
    parameter int DRAIN_CYCLES         = 4
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  start,
    input  logic                                                  stall_in,
    input  logic [(NUM_NEIGHBOR_CELLS_P+1)*PARTICLE_ID_WIDTH_P-1:0] cell_count,
    output logic                                                  phase,
    output logic                                                  reading_particle_num,
    output logic [PARTICLE_ID_WIDTH_P-1:0]                        particle_id,
    output logic [PARTICLE_ID_WIDTH_P-1:0]                        ref_id,
    output logic                                                  pause_reading,
    output logic                                                  busy,
    output logic                                                  iter_done
);
    localparam int W         = PARTICLE_ID_WIDTH_P;
    localparam int NUM_CELLS = NUM_NEIGHBOR_CELLS_P + 1;
    localparam int TICK_MAX  = (RD_LATENCY > DRAIN_CYCLES) ? RD_LATENCY : DRAIN_CYCLES;
    localparam int TICK_W    = $clog2(TICK_MAX + 1);

    pos_rd_state_t state_reg;
    logic [TICK_W-1:0] tick_reg;
    logic [W-1:0]      home_cnt_reg;
    logic [W-1:0]      max_cnt_reg;
    logic [W-1:0]      max_cnt_comb;
    logic [W-1:0]      home_cnt_comb;

    assign home_cnt_comb = cell_count[W-1:0];

    cell_count_max #(
        .NUM_CELLS(NUM_CELLS),
        .W        (W)
    ) u_max (
        .counts (cell_count),
        .max_cnt(max_cnt_comb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg            <= IDLE;
            tick_reg             <= '0;
            home_cnt_reg         <= '0;
            max_cnt_reg          <= '0;
            phase                <= 1'b0;
            reading_particle_num <= 1'b0;
            particle_id          <= '0;
            ref_id               <= '0;
            pause_reading        <= 1'b0;
            busy                 <= 1'b0;
            iter_done            <= 1'b0;
        end else begin
            pause_reading <= stall_in;
            iter_done     <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    // A start coinciding with the completion pulse belongs to the old sweep.
                    if (start && !iter_done) begin
                        state_reg            <= RD_NUM;
                        reading_particle_num <= 1'b1;
                        particle_id          <= '0;
                        phase                <= 1'b0;
                        busy                 <= 1'b1;
                    end
                end
                RD_NUM: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        state_reg            <= WAIT_CNT;
                        reading_particle_num <= 1'b0;
                        phase                <= 1'b0;
                        tick_reg             <= '0;
                    end
                end
                WAIT_CNT: begin
                    if (tick_reg == TICK_W'(RD_LATENCY - 1)) begin
                        home_cnt_reg <= home_cnt_comb;
                        max_cnt_reg  <= max_cnt_comb;
                        ref_id       <= W'(1);
                        tick_reg     <= '0;
                        if (home_cnt_comb == '0 || max_cnt_comb == '0) begin
                            state_reg <= DRAIN;
                        end else begin
                            state_reg   <= BCAST;
                            particle_id <= W'(1);
                            phase       <= 1'b0;
                        end
                    end else begin
                        tick_reg <= tick_reg + 1'b1;
                    end
                end
                BCAST: begin
                    if (!stall_in) begin
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (particle_id == max_cnt_reg) begin
                                if (ref_id < home_cnt_reg) begin
                                    ref_id      <= ref_id + 1'b1;
                                    particle_id <= W'(1);
                                end else begin
                                    // ref_id past the last home particle signals reading_done downstream.
                                    ref_id    <= home_cnt_reg + 1'b1;
                                    state_reg <= DRAIN;
                                    tick_reg  <= '0;
                                end
                            end else begin
                                particle_id <= particle_id + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (tick_reg == TICK_W'(DRAIN_CYCLES - 1)) begin
                        state_reg   <= IDLE;
                        iter_done   <= 1'b1;
                        busy        <= 1'b0;
                        particle_id <= '0;
                        ref_id      <= '0;
                        phase       <= 1'b0;
                        tick_reg    <= '0;
                    end else begin
                        tick_reg <= tick_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
